// File: rtl/cobro_bebidas.sv
// Drink vending payment controller: accepts 5/10-unit coins, charges coffee
// or tea, drives the brewing controller start pulses and refunds leftover
// credit one 5-unit coin per cycle. All outputs are registered.
module cobro_bebidas #(
    parameter int unsigned PRECIO_CAFE = 15,
    parameter int unsigned PRECIO_TE   = 10,
    parameter int unsigned CREDITO_MAX = 40,
    parameter int unsigned TIMEOUT     = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       moneda_5,
    input  logic       moneda_10,
    input  logic       sel_cafe,
    input  logic       sel_te,
    input  logic       cancelar,
    input  logic       hay_agua,
    input  logic       hay_materia,
    input  logic       listo_prep,
    output logic       iniciar_cafe,
    output logic       iniciar_te,
    output logic [5:0] credito,
    output logic       devolver,
    output logic       rechazo,
    output logic       ocupado
);

    typedef enum logic [2:0] {
        IDLE,
        CREDITO,
        INICIO,
        PREPARANDO,
        CAMBIO
    } estado_t;

    localparam int unsigned TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
    localparam logic [5:0] P_CAFE  = 6'(PRECIO_CAFE);
    localparam logic [5:0] P_TE    = 6'(PRECIO_TE);
    localparam logic [6:0] MAX7    = 7'(CREDITO_MAX);

    estado_t       estado_q;
    logic [TW-1:0] tmr_q;
    logic [5:0]    credito_q;
    logic          iniciar_cafe_q;
    logic          iniciar_te_q;
    logic          devolver_q;
    logic          rechazo_q;
    logic          ocupado_q;

    logic       hay_moneda;
    logic       moneda_ok;
    logic       moneda_rej;
    logic [6:0] suma;
    logic [5:0] credito_moneda;
    logic       sel_ok;
    logic [5:0] precio;

    // Coin acceptance and selection qualification for the current credit
    always_comb begin
        hay_moneda     = moneda_5 | moneda_10;
        moneda_ok      = 1'b0;
        moneda_rej     = 1'b0;
        suma           = {1'b0, credito_q};
        credito_moneda = credito_q;
        if (moneda_10) begin
            suma = {1'b0, credito_q} + 7'd10;
            // the 5 is always lost when both coins arrive together
            moneda_rej = moneda_5;
            if (suma <= MAX7) begin
                moneda_ok = 1'b1;
            end else begin
                moneda_rej = 1'b1;
            end
        end else if (moneda_5) begin
            suma = {1'b0, credito_q} + 7'd5;
            if (suma <= MAX7) begin
                moneda_ok = 1'b1;
            end else begin
                moneda_rej = 1'b1;
            end
        end
        credito_moneda = suma[5:0];

        // coffee wins when both buttons are pressed
        precio = sel_cafe ? P_CAFE : P_TE;
        sel_ok = (sel_cafe | sel_te) & hay_agua & hay_materia & (credito_q >= precio);
    end

    // Main controller FSM with registered pulse outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q       <= IDLE;
            tmr_q          <= '0;
            credito_q      <= '0;
            iniciar_cafe_q <= 1'b0;
            iniciar_te_q   <= 1'b0;
            devolver_q     <= 1'b0;
            rechazo_q      <= 1'b0;
            ocupado_q      <= 1'b0;
        end else begin
            iniciar_cafe_q <= 1'b0;
            iniciar_te_q   <= 1'b0;
            devolver_q     <= 1'b0;
            rechazo_q      <= 1'b0;
            case (estado_q)
                IDLE: begin
                    rechazo_q <= moneda_rej;
                    if (moneda_ok) begin
                        credito_q <= credito_moneda;
                        tmr_q     <= '0;
                        estado_q  <= CREDITO;
                    end
                end
                CREDITO: begin
                    if (cancelar) begin
                        rechazo_q <= hay_moneda;
                        estado_q  <= CAMBIO;
                        ocupado_q <= 1'b1;
                    end else if (sel_ok) begin
                        rechazo_q      <= hay_moneda;
                        credito_q      <= credito_q - precio;
                        iniciar_cafe_q <= sel_cafe;
                        iniciar_te_q   <= ~sel_cafe;
                        estado_q       <= INICIO;
                        ocupado_q      <= 1'b1;
                    end else begin
                        rechazo_q <= moneda_rej;
                        if (moneda_ok) begin
                            credito_q <= credito_moneda;
                            tmr_q     <= '0;
                        end else if (tmr_q == TMAX) begin
                            estado_q  <= CAMBIO;
                            ocupado_q <= 1'b1;
                        end else begin
                            tmr_q <= tmr_q + 1'b1;
                        end
                    end
                end
                INICIO: begin
                    rechazo_q <= hay_moneda;
                    estado_q  <= PREPARANDO;
                end
                PREPARANDO: begin
                    rechazo_q <= hay_moneda;
                    if (listo_prep) begin
                        if (credito_q != '0) begin
                            estado_q <= CAMBIO;
                        end else begin
                            estado_q  <= IDLE;
                            ocupado_q <= 1'b0;
                        end
                    end
                end
                CAMBIO: begin
                    rechazo_q <= hay_moneda;
                    if (credito_q != '0) begin
                        devolver_q <= 1'b1;
                        credito_q  <= credito_q - 6'd5;
                    end
                    // last coin leaves this cycle: return to IDLE on the same edge
                    if (credito_q <= 6'd5) begin
                        estado_q  <= IDLE;
                        ocupado_q <= 1'b0;
                    end
                end
                default: begin
                    estado_q  <= IDLE;
                    ocupado_q <= 1'b0;
                end
            endcase
        end
    end

    assign iniciar_cafe = iniciar_cafe_q;
    assign iniciar_te   = iniciar_te_q;
    assign credito      = credito_q;
    assign devolver     = devolver_q;
    assign rechazo      = rechazo_q;
    assign ocupado      = ocupado_q;

endmodule
